// File: rtl/puf_pkg.sv
// Shared constants and types for the RO-PUF response path: UART framing,
// default response geometry and the transmitter state encoding.
package puf_pkg;

  localparam int DATA_BITS        = 8;
  localparam int FRAME_BITS       = 10;  // start + 8 data + stop
  localparam int DEF_RESP_BITS    = 16;
  localparam int DEF_CLKS_PER_BIT = 868;
  localparam int DEF_CNT_W        = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Index width that stays legal when there is only a single byte to count.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 UART transmitter. A byte is accepted whenever o_ready and
// i_valid are both high; o_ready also rises in the final stop-bit cycle so
// back-to-back frames leave no idle gap on the line.
module uart_tx_byte
  import puf_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_valid,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_t          r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [BIT_W-1:0]     r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_bit_end;
  logic                 w_accept;

  assign w_bit_end = (r_cnt == '0);
  assign o_ready   = (r_state == IDLE) || ((r_state == STOP) && w_bit_end);
  assign w_accept  = i_valid && o_ready;

  assign o_tx   = r_tx;
  assign o_busy = r_busy;
  assign o_done = r_done;

  // NOTE: every register here is written with <= so all of them update from
  // the same pre-edge values; a blocking '=' would let later lines see new state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_state <= START;
        r_shift <= i_data;
        r_cnt   <= CNT_RELOAD;
        r_tx    <= 1'b0;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          IDLE: r_tx <= 1'b1;
          START: begin
            if (w_bit_end) begin
              r_state <= DATA;
              r_cnt   <= CNT_RELOAD;
              r_bit   <= '0;
              r_tx    <= r_shift[0];
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          DATA: begin
            if (w_bit_end) begin
              r_cnt <= CNT_RELOAD;
              if (r_bit == BIT_W'(DATA_BITS - 1)) begin
                r_state <= STOP;
                r_tx    <= 1'b1;
              end else begin
                // LSB-first: the next bit out is the one above the current LSB.
                r_bit   <= r_bit + BIT_W'(1);
                r_shift <= r_shift >> 1;
                r_tx    <= r_shift[1];
              end
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          STOP: begin
            if (w_bit_end) begin
              r_state <= IDLE;
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/puf_resp_uart_tx.sv
// Collects PUF comparator bits, freezes the word on the controller's done
// rise and streams it MSB-byte-first over UART, flagging overlapping requests.
module puf_resp_uart_tx
  import puf_pkg::*;
#(
  parameter int RESP_BITS    = DEF_RESP_BITS,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sr_en,
  input  logic                         resp_bit,
  input  logic                         done,
  output logic                         tx,
  output logic                         busy,
  output logic                         tx_done,
  output logic                         overrun,
  output logic [$clog2(RESP_BITS):0]   bit_cnt
);

  localparam int N_BYTES = RESP_BITS / DATA_BITS;
  localparam int IDX_W   = idx_width(N_BYTES);
  localparam int BCNT_W  = $clog2(RESP_BITS) + 1;

  logic [RESP_BITS-1:0] r_cap;
  logic [RESP_BITS-1:0] r_txbuf;
  logic [BCNT_W-1:0]    r_bit_cnt;
  logic [IDX_W-1:0]     r_byte_idx;
  logic                 r_done_q;
  logic                 r_overrun;

  logic [RESP_BITS-1:0] w_cap_next;
  logic [RESP_BITS-1:0] w_txbuf_shl;
  logic [DATA_BITS-1:0] w_byte_data;
  logic                 w_rise;
  logic                 w_latch;
  logic                 w_chain;
  logic                 w_byte_valid;
  logic                 w_byte_ready;
  logic                 w_busy;

  // The latch takes the word as it would look after this cycle's shift, so a
  // strobe coincident with done is not lost.
  assign w_cap_next   = sr_en ? {r_cap[RESP_BITS-2:0], resp_bit} : r_cap;
  assign w_txbuf_shl  = r_txbuf << DATA_BITS;
  assign w_rise       = done && !r_done_q;
  assign w_latch      = w_rise && !w_busy;
  assign w_chain      = w_busy && w_byte_ready && (r_byte_idx != IDX_W'(N_BYTES - 1));
  assign w_byte_valid = w_latch || w_chain;
  assign w_byte_data  = w_latch ? w_cap_next[RESP_BITS-1 -: DATA_BITS]
                                : w_txbuf_shl[RESP_BITS-1 -: DATA_BITS];

  assign busy    = w_busy;
  assign overrun = r_overrun;
  assign bit_cnt = r_bit_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cap      <= '0;
      r_txbuf    <= '0;
      r_bit_cnt  <= '0;
      r_byte_idx <= '0;
      r_done_q   <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_done_q <= done;
      if (w_rise && w_busy) r_overrun <= 1'b1;
      if (w_latch) begin
        r_txbuf    <= w_cap_next;
        r_cap      <= '0;
        r_bit_cnt  <= '0;
        r_byte_idx <= '0;
      end else begin
        if (sr_en) begin
          r_cap <= w_cap_next;
          if (r_bit_cnt != BCNT_W'(RESP_BITS)) r_bit_cnt <= r_bit_cnt + BCNT_W'(1);
        end
        // The buffer shifts up as each byte goes out; its top byte is next.
        if (w_chain) begin
          r_txbuf    <= w_txbuf_shl;
          r_byte_idx <= r_byte_idx + IDX_W'(1);
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_uart_tx_byte (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_byte_valid),
    .i_data  (w_byte_data),
    .o_ready (w_byte_ready),
    .o_tx    (tx),
    .o_busy  (w_busy),
    .o_done  (tx_done)
  );

endmodule

// File: tb/tb_puf_resp_uart_tx.sv
// Scoreboard bench for puf_resp_uart_tx: stimulus queues expected bytes, a
// line monitor decodes UART frames from tx and compares them in order.
module tb_puf_resp_uart_tx;
  import puf_pkg::*;

  localparam int RB    = 16;
  localparam int CPB   = 4;
  localparam int CW    = 3;
  localparam int BCW   = $clog2(RB) + 1;
  localparam int FRAME = FRAME_BITS * CPB;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           sr_en = 1'b0;
  logic           resp_bit = 1'b0;
  logic           done = 1'b0;
  logic           tx;
  logic           busy;
  logic           tx_done;
  logic           overrun;
  logic [BCW-1:0] bit_cnt;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];

  bit         mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = '0;

  puf_resp_uart_tx #(
    .RESP_BITS    (RB),
    .CLKS_PER_BIT (CPB),
    .CNT_W        (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sr_en    (sr_en),
    .resp_bit (resp_bit),
    .done     (done),
    .tx       (tx),
    .busy     (busy),
    .tx_done  (tx_done),
    .overrun  (overrun),
    .bit_cnt  (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic shift_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sr_en    = 1'b1;
      resp_bit = val[i];
      tick();
    end
    sr_en    = 1'b0;
    resp_bit = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic wait_tx_done(input string name, input int budget);
    logic seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (tx_done) seen = 1'b1;
      else tick();
    end
    check(name, seen, 1);
  endtask

  // Line monitor: decode each frame at mid-bit and compare to the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt >= CPB && mon_cnt < 9 * CPB && (mon_cnt % CPB) == CPB / 2)
        mon_byte[mon_cnt / CPB - 1] = tx;
      if (mon_cnt == 9 * CPB + CPB / 2) begin
        check("stop_bit", tx, 1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no frame", mon_byte);
        end else begin
          check("rx_byte", mon_byte, exp_q.pop_front());
        end
        mon_active = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;

    // Reset state
    reset = 1'b1;
    tick(3);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_bit_cnt", bit_cnt, 0);
    reset = 1'b0;
    tick();

    // Full 16-bit word with exact frame timing
    shift_bits(32'hA53C, 16);
    check("t1_bit_cnt", bit_cnt, 16);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    pulse_done();                       // now in cycle done+1
    check("t1_start_tx", tx, 0);
    check("t1_start_busy", busy, 1);
    check("t1_bit_cnt_clr", bit_cnt, 0);
    tick(39);                           // done+40: last stop cycle of byte 0
    check("t1_stop0_tx", tx, 1);
    check("t1_stop0_busy", busy, 1);
    tick();                             // done+41: start of byte 1
    check("t1_start1_tx", tx, 0);
    tick(39);                           // done+80
    check("t1_pre_done", tx_done, 0);
    check("t1_pre_busy", busy, 1);
    tick();                             // done+81
    check("t1_tx_done", tx_done, 1);
    check("t1_done_busy", busy, 0);
    check("t1_done_tx", tx, 1);
    tick();
    check("t1_done_pulse_len", tx_done, 0);
    check("t1_q_empty", exp_q.size(), 0);

    // 16th bit coincident with done
    shift_bits(32'hC3E1 >> 1, 15);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'hE1);
    sr_en    = 1'b1;
    resp_bit = 1'b1;
    done     = 1'b1;
    tick();
    sr_en = 1'b0;
    done  = 1'b0;
    check("t2_bit_cnt_clr", bit_cnt, 0);
    check("t2_busy", busy, 1);
    wait_tx_done("t2_tx_done", 100);
    tick();

    // Short 12-bit capture, zero-extended
    shift_bits(32'hABC, 12);
    check("t3_bit_cnt", bit_cnt, 12);
    exp_q.push_back(8'h0A);
    exp_q.push_back(8'hBC);
    pulse_done();
    wait_tx_done("t3_tx_done", 100);
    tick();

    // 20 bits: count saturates, oldest bits fall off
    shift_bits(32'hF1234, 20);
    check("t_sat_bit_cnt", bit_cnt, 16);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    pulse_done();
    wait_tx_done("t_sat_tx_done", 100);
    tick();

    // Overrun: second done during byte 0; capture continues meanwhile
    shift_bits(32'h1E96, 16);
    exp_q.push_back(8'h1E);
    exp_q.push_back(8'h96);
    pulse_done();
    tick(8);
    shift_bits(32'hD, 4);
    check("t4_cap_during_tx", bit_cnt, 4);
    pulse_done();
    check("t4_overrun", overrun, 1);
    check("t4_cap_kept", bit_cnt, 4);
    wait_tx_done("t4_tx_done", 100);
    check("t4_overrun_sticky", overrun, 1);
    tick();

    // done held 5 cycles; word combines bits gathered during the last send
    shift_bits(32'h5F0, 12);
    check("t5_bit_cnt", bit_cnt, 16);
    exp_q.push_back(8'hD5);
    exp_q.push_back(8'hF0);
    done = 1'b1;
    tick(5);
    done = 1'b0;
    wait_tx_done("t5_tx_done", 100);
    tick();
    cnt = 0;
    for (int i = 0; i < 120; i++) begin
      if (busy) cnt++;
      tick();
    end
    check("t5_single_seq", cnt, 0);
    check("t5_q_empty", exp_q.size(), 0);

    // Reset at frame cycle 20
    shift_bits(32'h6699, 16);
    exp_q.push_back(8'h66);
    exp_q.push_back(8'h99);
    pulse_done();                       // frame cycle 0
    tick(20);                           // frame cycle 20
    exp_q.delete();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_tx", tx, 1);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_overrun", overrun, 0);
    check("t6_rst_bit_cnt", bit_cnt, 0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (tx_done || !tx) cnt++;
      tick();
    end
    check("t6_quiet_after_rst", cnt, 0);
    shift_bits(32'h5AC3, 16);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hC3);
    pulse_done();
    check("t6_restart_tx", tx, 0);
    wait_tx_done("t6_tx_done", 100);
    tick(3);
    check("final_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/puf_resp_uart_tx.md
Name: puf_resp_uart_tx

Overview:
Consumer end of the RO-PUF evaluation controller's response interface. Captures the comparator bits the controller strobes out with its shift-register enable. On the controller's done pulse, freezes the assembled response word. Serialises that word over a UART 8N1 link to the IoT host. Sits between the CONTROL FSM/comparator and the board-level TX pin.

Parameters:
RESP_BITS, 16, response width in bits; must be a multiple of 8 and ≥8
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be ≥2
CNT_W, 10, baud counter width; must satisfy 2^CNT_W > CLKS_PER_BIT

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
sr_en  in  1  bit strobe from controller (srEN); resp_bit valid in that cycle
resp_bit  in  1  comparator output, sampled only when sr_en=1
done  in  1  controller evaluation-complete pulse (≥1 cycle high)
tx  out  1  UART serial line, idle high
busy  out  1  high while a frame sequence is in progress
tx_done  out  1  one-cycle pulse after the last stop bit of the last byte
overrun  out  1  sticky: done seen while busy; cleared only by reset
bit_cnt  out  log2(RESP_BITS)+1  bits captured since last latch (saturates at RESP_BITS)

Behaviour:
- Reset values: tx=1, busy=0, tx_done=0, overrun=0, bit_cnt=0. Capture register, tx buffer, counters and FSM (IDLE) all cleared.
- Capture: on sr_en=1, cap <= {cap[RESP_BITS-2:0], resp_bit}. bit_cnt increments and saturates at RESP_BITS. Extra bits keep shifting, so the oldest bits drop off.
- done detection: rising edge only (done & ~done_q), so a multi-cycle done latches once.
- Latch, when a done rise occurs and busy=0:
  - txbuf <= the value cap would take this cycle, including a same-cycle sr_en bit.
  - cap and bit_cnt clear to 0.
  - FSM goes to START.
  - A short capture (bit_cnt<RESP_BITS) is latched as-is, zero-extended in the upper bits.
- done rise while busy=1:
  - overrun <= 1.
  - txbuf is untouched and the current transmission continues.
  - cap is not cleared.
- Latency: done rise in cycle t → busy=1 and tx=0 (start bit) from cycle t+1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. Leaves on a latch.
  - START: tx=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: 8 bits, LSB-first, each CLKS_PER_BIT cycles → STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If more bytes remain → START of the next byte (no idle gap). Otherwise → IDLE with a tx_done pulse in the first IDLE cycle.
- Byte order: most significant byte first, i.e. txbuf[RESP_BITS-1 -: 8] then downward. A byte index counts 0..RESP_BITS/8-1.
- Baud counter: loads CLKS_PER_BIT-1 on each bit entry, decrements to 0, and the bit ends on the 0 cycle. One frame is exactly 10*CLKS_PER_BIT cycles.
- busy is high from the latch cycle+1 through the last STOP cycle inclusive. It is low in the cycle tx_done is high.
- sr_en during transmission: capture proceeds normally, so the next evaluation can be gathered while the previous one sends.
- Reset mid-frame: tx returns to 1 the next cycle and the partial frame is abandoned. No tx_done pulse.

Decomposition:
- Package puf_pkg:
  - FSM state enum (IDLE/START/DATA/STOP).
  - UART constants: DATA_BITS=8, frame length 10.
  - Default RESP_BITS and CLKS_PER_BIT, shared with CONTROL and the top level.
- Sub-module uart_tx_byte: a single-byte 8N1 transmitter with a valid/ready handshake.
- puf_resp_uart_tx owns capture, latch, byte sequencing and overrun.

Test Plan:
- RESP_BITS=16, CLKS_PER_BIT=4. Shift 0xA53C MSB-first with sr_en on 16 cycles, pulse done → tx carries byte 0xA5 then 0x3C, each LSB-first. Each frame is 40 cycles. Start bit in the cycle after done. tx_done pulses at cycle done+81.
- 16 bits shifted with the 16th bit's sr_en coincident with done → that bit is included in the latched word, and bit_cnt reads 0 the next cycle.
- Only 12 bits (0xABC) shifted, then done → bytes 0x0A, 0xBC are sent.
- Second done pulse during byte 0 → overrun=1 and stays 1. Transmitted bytes are unchanged. No second sequence starts.
- done held high 5 cycles → exactly one 2-byte sequence is sent.
- Reset asserted at cycle 20 of a frame → tx=1, busy=0 the next cycle. No tx_done. A new done afterwards transmits normally.
